instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the main instruction decoder: accepts abstract instruction descriptors (operation class plus register and immediate fields) over a valid/ready handshake.
- Encodes each descriptor into a 32-bit MIPS machine word.
- Writes the words to consecutive instruction-memory addresses through a granted write port.
- Used by the bench/boot path to load programs into imem, and to cross-check the decoder against independently built encodings.

Parameters:
ADDR_W, 8, imem word-address width
MAX_WORDS, 64, maximum words written per load session

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin session at base_addr
base_addr  in  ADDR_W  first word address of session
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid & in_ready
in_op  in  4  0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 JR,6 LW,7 SW,8 BEQ,9 ADDI,10 J,11 JAL,12-15 illegal
in_rs, in_rt, in_rd  in  5 each  register fields
in_imm  in  32  signed imm / branch word offset / jump word target
imem_we  out  1  write request, held until granted
imem_addr  out  ADDR_W  write address
imem_wdata  out  32  encoded word
imem_gnt  in  1  write completes in a cycle where imem_we & imem_gnt
busy  out  1  state RUN
done  out  1  state DONE
err  out  1  sticky encode error
err_op  out  4  in_op of first rejected descriptor
words_written  out  $clog2(MAX_WORDS+1)  words committed this session

Behaviour:
- Reset (async, any time, including mid-write):
  - FSM to IDLE.
  - All outputs 0: imem_we, imem_addr, imem_wdata, err, err_op, words_written, in_ready.
  - Any pending write is discarded.
- FSM IDLE -> RUN on start:
  - Address counter loads base_addr.
  - words_written cleared to 0.
  - err and err_op cleared.
- FSM RUN -> DONE the cycle the write making words_written == MAX_WORDS is granted.
- FSM DONE -> RUN on start, with the same initialisation as IDLE -> RUN.
- start while in RUN is ignored.
- in_ready = RUN & (!imem_we | imem_gnt) & (words_written + imem_we < MAX_WORDS). This combinational path is intentional: one descriptor per cycle at full throughput.
- Write timing:
  - A descriptor accepted in cycle N appears in cycle N+1 as imem_we=1, with imem_addr/imem_wdata registered.
  - The write holds stable until granted.
  - On grant: address increments (wraps modulo 2^ADDR_W) and words_written increments.
  - Acceptance in the same cycle as a grant replaces the output register back-to-back.
- Encoding:
  - R-type (op 0-5): opcode 000000, shamt 0. funct: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, JR 001000.
  - JR forces rt = rd = 0.
  - LW 100011, SW 101011, BEQ 000100, ADDI 001000: rs, rt, imm[15:0].
  - J 000010, JAL 000011: imm[25:0].
- Range rules:
  - I-type requires in_imm[31:15] all equal (signed 16-bit fit).
  - J/JAL require in_imm[31:26] == 0.
- Rejection (range violation or op 12-15):
  - Descriptor is still accepted (in_ready handshake completes).
  - No write is issued and address/count are unchanged.
  - err is set; err_op captures only the first offender.
  - err does not halt the session.
- No descriptor is accepted in IDLE or DONE.

Optional Feature:
- Macro: INSTR_ENCODER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0], the XOR of every granted imem_wdata in the session.
  - checksum clears on session start and on reset, and updates in the grant cycle.
- When undefined: port and logic absent; other behaviour identical.

Test Plan:
- Reset low mid-write (imem_we=1, gnt=0) -> all outputs 0 the same cycle; after release, FSM in IDLE and in_ready=0.
- start with base_addr=0x10, gnt tied 1; stream ADD rd16 rs17 rt18, LW rt2 rs0 imm80, ADDI rt2 rs0 imm-1, BEQ rs2 rt7 imm10, JR rs31:
  - Words 0x02328020, 0x8C020050, 0x2002FFFF, 0x1047000A, 0x03E00008 written at addresses 0x10-0x14 on consecutive cycles.
  - words_written=5.
- J imm 0x11 then JAL imm 0x11, gnt held low 3 cycles -> 0x08000011 held stable and in_ready=0 throughout; after grant, 0x0C000011 written.
- ADDI imm 0x8000, then op 13, then SW rt3 rs29 imm4:
  - err=1, err_op=9, no writes for the first two.
  - One write 0xAFA30004 at base_addr.
- MAX_WORDS=4, base_addr=0xFE, 5 valid descriptors:
  - Addresses 0xFE, 0xFF, 0x00, 0x01; done=1; fifth descriptor never accepted.
  - A new start returns the FSM to RUN with words_written=0.
- With INSTR_ENCODER_CHECKSUM_EN, words 0x02328020 and 0x8C020050 -> checksum = 0x8E308070.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes abstract instruction descriptors into MIPS words and streams them into imem.
// Optional running XOR of written words: define INSTR_ENCODER_CHECKSUM_EN.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_gnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        err_op,
    output logic [CW-1:0]     words_written
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW:0]   MAXW  = (CW+1)'(MAX_WORDS);
    localparam logic [CW-1:0] LASTW = CW'(MAX_WORDS - 1);

    state_t      state, state_nxt;
    logic        grant, accept, start_ok, last_grant;
    logic [CW:0] ww_pend;
    logic [31:0] enc_word;
    logic        enc_bad;

    assign grant      = imem_we & imem_gnt;
    assign last_grant = grant & (words_written == LASTW);
    assign start_ok   = start & (state != RUN);
    // Count the in-flight write too, so the session never overshoots MAX_WORDS.
    assign ww_pend    = {1'b0, words_written} + {{CW{1'b0}}, imem_we};
    assign in_ready   = (state == RUN) & (~imem_we | imem_gnt) & (ww_pend < MAXW);
    assign accept     = in_valid & in_ready;

    always_comb begin
        logic [5:0] funct;
        logic [5:0] opc;
        logic       imm_ok;
        logic       j_ok;
        enc_word = '0;
        enc_bad  = 1'b0;
        funct    = 6'b000000;
        opc      = 6'b000000;
        imm_ok   = (&in_imm[31:15]) | ~(|in_imm[31:15]);
        j_ok     = ~(|in_imm[31:26]);
        case (in_op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                case (in_op)
                    4'd0:    funct = 6'b100000;
                    4'd1:    funct = 6'b100010;
                    4'd2:    funct = 6'b100100;
                    4'd3:    funct = 6'b100101;
                    default: funct = 6'b101010;
                endcase
                enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, funct};
            end
            4'd5: enc_word = {6'b000000, in_rs, 5'b00000, 5'b00000, 5'b00000, 6'b001000};
            4'd6, 4'd7, 4'd8, 4'd9: begin
                case (in_op)
                    4'd6:    opc = 6'b100011;
                    4'd7:    opc = 6'b101011;
                    4'd8:    opc = 6'b000100;
                    default: opc = 6'b001000;
                endcase
                enc_word = {opc, in_rs, in_rt, in_imm[15:0]};
                enc_bad  = ~imm_ok;
            end
            4'd10, 4'd11: begin
                opc      = (in_op == 4'd10) ? 6'b000010 : 6'b000011;
                enc_word = {opc, in_imm[25:0]};
                enc_bad  = ~j_ok;
            end
            default: enc_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_grant) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            err           <= 1'b0;
            err_op        <= '0;
            words_written <= '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else if (start_ok) begin
            imem_we       <= 1'b0;
            imem_addr     <= base_addr;
            err           <= 1'b0;
            err_op        <= '0;
            words_written <= '0;
`ifdef INSTR_ENCODER_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            if (grant) begin
                imem_addr     <= imem_addr + ADDR_W'(1);
                words_written <= words_written + CW'(1);
`ifdef INSTR_ENCODER_CHECKSUM_EN
                checksum      <= checksum ^ imem_wdata;
`endif
            end
            // A rejected descriptor completes its handshake but leaves no write behind.
            if (accept) begin
                if (enc_bad) begin
                    imem_we <= 1'b0;
                    if (!err) begin
                        err    <= 1'b1;
                        err_op <= in_op;
                    end
                end else begin
                    imem_we    <= 1'b1;
                    imem_wdata <= enc_word;
                end
            end else if (grant) begin
                imem_we <= 1'b0;
            end
        end
    end

endmodule
